// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Sequential signed 32x32 multiply / divide unit for the multicycle CPU.
//   MULT uses radix-2 Booth recoding; DIV uses restoring division on operand
//   magnitudes with sign fix-up at the end. Both need 32 iterations, one per
//   clock. The results land in HI/LO, which MFHI/MFLO may read at any time.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   start_mult : request a signed multiply a*b (sampled in IDLE only)
//   start_div  : request a signed divide a/b (sampled in IDLE only)
//   a          : multiplicand / dividend
//   b          : multiplier / divisor
//   hi         : product[63:32] or remainder
//   lo         : product[31:0] or quotient
//   busy       : high whenever the unit is not IDLE
//   done       : one-cycle completion pulse
//   div_zero   : one-cycle pulse alongside done when the divisor was zero
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // r_acc is 33 bits so that Booth subtraction of -2^31 cannot overflow.
    // In divide mode only r_acc[31:0] is used (partial remainder).
    logic [32:0] r_acc;
    logic [31:0] r_q;        // multiplier (MULT) / dividend-then-quotient (DIV)
    logic [31:0] r_m;        // multiplicand (MULT) / divisor magnitude (DIV)
    logic        r_qm1;      // Booth q(-1) bit
    logic [4:0]  r_count;
    logic        r_sign_q;
    logic        r_sign_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_div_zero;

    logic        w_last;
    logic [32:0] w_m_ext;
    logic [32:0] w_booth_sum;
    logic [32:0] w_mul_acc;
    logic [31:0] w_mul_q;
    logic [31:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_div_ge;
    logic [31:0] w_div_rem;
    logic [31:0] w_div_q;
    logic [31:0] w_quot;
    logic [31:0] w_remd;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_last = (r_count == 5'd31);

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_mult)
                    w_next = S_MULT;
                else if (start_div)
                    w_next = (b == '0) ? S_DONE : S_DIV;
            end
            S_MULT:  if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // ---------------- Booth step ----------------
    always_comb begin
        w_m_ext = {r_m[31], r_m};
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
        // arithmetic shift right of {acc, q}
        w_mul_acc = {w_booth_sum[32], w_booth_sum[32:1]};
        w_mul_q   = {w_booth_sum[0], r_q[31:1]};
    end

    // ---------------- restoring divide step ----------------
    // Partial remainder is always < divisor <= 2^31, so the shifted value
    // fits in 32 bits and r_acc[31] is never needed here.
    always_comb begin
        w_div_shift = {r_acc[30:0], r_q[31]};
        w_div_diff  = {1'b0, w_div_shift} - {1'b0, r_m};
        w_div_ge    = ~w_div_diff[32];
        w_div_rem   = w_div_ge ? w_div_diff[31:0] : w_div_shift;
        w_div_q     = {r_q[30:0], w_div_ge};
        w_quot      = r_sign_q ? (-w_div_q)   : w_div_q;
        w_remd      = r_sign_r ? (-w_div_rem) : w_div_rem;
    end

    // 0x80000000 negates to itself, which is its correct unsigned magnitude.
    assign w_a_mag = a[31] ? (-a) : a;
    assign w_b_mag = b[31] ? (-b) : b;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc      <= '0;
            r_q        <= '0;
            r_m        <= '0;
            r_qm1      <= 1'b0;
            r_count    <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= (w_next == S_DONE);
            r_div_zero <= (r_state == S_IDLE) && (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_MULT) begin
                        r_acc   <= '0;
                        r_m     <= a;
                        r_q     <= b;
                        r_qm1   <= 1'b0;
                        r_count <= '0;
                    end else if (w_next == S_DIV) begin
                        r_acc    <= '0;
                        r_m      <= w_b_mag;
                        r_q      <= w_a_mag;
                        r_sign_q <= a[31] ^ b[31];
                        r_sign_r <= a[31];
                        r_count  <= '0;
                    end
                end
                S_MULT: begin
                    r_acc   <= w_mul_acc;
                    r_q     <= w_mul_q;
                    r_qm1   <= r_q[0];
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_hi <= w_mul_acc[31:0];
                        r_lo <= w_mul_q;
                    end
                end
                S_DIV: begin
                    r_acc   <= {1'b0, w_div_rem};
                    r_q     <= w_div_q;
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_hi <= w_remd;
                        r_lo <= w_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: table of operations with expected HI/LO,
// div_zero and latency, a scoreboard queue of expectations, and hand-written
// sequences for start-during-busy, simultaneous starts and mid-op reset.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = mult, 1 = div, 2 = both starts together
    typedef struct {
        int          kind;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t model(input int kind, input logic [31:0] ma, input logic [31:0] mb);
        exp_t   e;
        longint sa, sb, p, q, r;
        logic [63:0] pv;
        logic [63:0] qv;
        logic [63:0] rv;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        e.dz  = 1'b0;
        e.lat = 32;
        if (kind == 1) begin
            q  = sa / sb;
            r  = sa % sb;
            qv = q;
            rv = r;
            e.lo = qv[31:0];
            e.hi = rv[31:0];
        end else begin
            p  = sa * sb;
            pv = p;
            e.hi = pv[63:32];
            e.lo = pv[31:0];
        end
        return e;
    endfunction

    // Drives one operation, waits for done, pops and compares the scoreboard.
    // inject >= 0 pulses start_div for one cycle that many edges into the op.
    task automatic do_op(input string name, input int kind, input logic [31:0] ta,
                         input logic [31:0] tb, input int inject);
        int   n;
        exp_t e;
        @(negedge clk);
        a          = ta;
        b          = tb;
        start_mult = (kind != 1);
        start_div  = (kind != 0);
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = $urandom;   // captured operands must not follow these
        b          = $urandom;
        check({name, " busy_after_start"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            start_div = (n == inject);
            @(posedge clk);
            #1;
            n++;
        end
        start_div = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s timeout: done not seen within %0d cycles", name, n);
            return;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard: done with no expectation queued", name);
            return;
        end
        e = exp_q.pop_front();
        check({name, " hi"},       hi, e.hi);
        check({name, " lo"},       lo, e.lo);
        check({name, " div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
        check({name, " latency"},  n, e.lat);
        @(posedge clk);
        #1;
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
        check({name, " busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic push_vec(input int kind, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] eh, input logic [31:0] el,
                            input logic edz, input int elat);
        vec_t v;
        v.kind = kind; v.op_a = va; v.op_b = vb;
        v.exp_hi = eh; v.exp_lo = el; v.exp_dz = edz; v.exp_lat = elat;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra, rb;

        // expected values from hand arithmetic
        push_vec(0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
        push_vec(0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 32);
        push_vec(1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
        push_vec(1, 32'd100,      32'd7,        32'd2,         32'd14,        1'b0, 32);
        push_vec(0, 32'd5,        32'd3,        32'd0,         32'd15,        1'b0, 32);
        push_vec(1, 32'd1234,     32'd0,        32'd0,         32'd15,        1'b1, 0);
        push_vec(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 32);
        push_vec(1, 32'd7,        32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 32);
        push_vec(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1,         1'b0, 32);
        // both starts high with b = 0: multiply wins, no zero flag
        push_vec(2, 32'd9,        32'd0,        32'd0,         32'd0,         1'b0, 32);

        reset = 1'b0; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset hi",       hi, 32'd0);
        check("reset lo",       lo, 32'd0);
        check("reset busy",     {31'd0, busy}, 32'd0);
        check("reset done",     {31'd0, done}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);

        foreach (vecs[i]) begin
            e.hi = vecs[i].exp_hi; e.lo = vecs[i].exp_lo;
            e.dz = vecs[i].exp_dz; e.lat = vecs[i].exp_lat;
            exp_q.push_back(e);
            do_op($sformatf("vec%0d", i), vecs[i].kind, vecs[i].op_a, vecs[i].op_b, -1);
        end

        // start_div injected during a multiply is ignored
        exp_q.push_back(model(0, 32'd123456, 32'hFFFF_FCEB));
        do_op("mult_inject_div", 0, 32'd123456, 32'hFFFF_FCEB, 9);

        // random operations checked against a behavioural model
        for (int i = 0; i < 8; i++) begin
            int k;
            k  = i % 2;
            ra = $urandom;
            rb = $urandom;
            if (k == 1 && rb == 0) rb = 32'd1;
            if (i >= 6) rb = rb >> 20;
            if (k == 1 && rb == 0) rb = 32'd3;
            exp_q.push_back(model(k, ra, rb));
            do_op($sformatf("rand%0d", i), k, ra, rb, -1);
        end

        // reset during iteration 16 of a divide
        @(negedge clk);
        a = 32'd1000; b = 32'd3; start_div = 1'b1;
        @(posedge clk);
        #1;
        start_div = 1'b0;
        repeat (16) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset hi",       hi, 32'd0);
        check("midreset lo",       lo, 32'd0);
        check("midreset busy",     {31'd0, busy}, 32'd0);
        check("midreset done",     {31'd0, done}, 32'd0);
        check("midreset div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        e.hi = 32'd0; e.lo = 32'd12; e.dz = 1'b0; e.lat = 32;
        exp_q.push_back(e);
        do_op("after_reset_mult", 0, 32'd3, 32'd4, -1);

        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
